// File: rtl/uart_echo_ctrl_if.sv
// Parallel-side bundle between the UART, the echo controller and the digit display.
// master = echo controller side, slave = UART/board side.
interface uart_echo_ctrl_if #(
    parameter int FIFO_DEPTH    = 8,
    parameter int ERR_CNT_WIDTH = 32
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                     rxEmpty;
    logic [7:0]               datain;
    logic                     rxRead;
    logic                     rxOverrun;
    logic                     rxFramingError;
    logic                     rxBreakDetect;
    logic                     txEmpty;
    logic [7:0]               dataout;
    logic                     txWrite;
    logic [LVL_W-1:0]         fifoLevel;
    logic [ERR_CNT_WIDTH-1:0] errorCount;
    logic                     busy;

    modport master (
        input  rxEmpty, datain, rxOverrun, rxFramingError, rxBreakDetect, txEmpty,
        output rxRead, dataout, txWrite, fifoLevel, errorCount, busy
    );

    modport slave (
        output rxEmpty, datain, rxOverrun, rxFramingError, rxBreakDetect, txEmpty,
        input  rxRead, dataout, txWrite, fifoLevel, errorCount, busy
    );
endinterface

// File: rtl/uart_echo_ctrl.sv
// UART echo controller: drains received bytes into a FIFO, writes them back out and counts
// receiver error events. Define UART_ECHO_CASE_SWAP_EN to flip ASCII letter case on receive.
module uart_echo_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int ERR_CNT_WIDTH = 32
) (
    input logic              sysClk,
    input logic              Rst,
    uart_echo_ctrl_if.master bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_WAIT} rxState_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WRITE, TX_WAIT} txState_t;

    rxState_t rxState, rxNext;
    txState_t txState, txNext;

    logic [7:0]               mem [FIFO_DEPTH];
    logic [AW-1:0]            wrPtr, rdPtr;
    logic [LVL_W-1:0]         level;
    logic                     fifoFull, fifoEmpty;
    logic                     push, pop, loadOut;
    logic [7:0]               pushData, dataoutReg;
    logic                     busyReg;
    logic [2:0]               errFlags, errFlagsPrev_p0, errRise;
    logic [ERR_CNT_WIDTH-1:0] errCnt;

    function automatic logic [1:0] countRises(input logic [2:0] r);
        return {1'b0, r[0]} + {1'b0, r[1]} + {1'b0, r[2]};
    endfunction

    // Counter pins at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_WIDTH-1:0] satAdd(input logic [ERR_CNT_WIDTH-1:0] a,
                                                        input logic [1:0] b);
        logic [ERR_CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(ERR_CNT_WIDTH-1){1'b0}}, b};
        return sum[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}} : sum[ERR_CNT_WIDTH-1:0];
    endfunction

`ifdef UART_ECHO_CASE_SWAP_EN
    function automatic logic [7:0] swapCase(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

    assign pushData = swapCase(bus.datain);
`else
    assign pushData = bus.datain;
`endif

    assign fifoFull  = (level == LVL_W'(FIFO_DEPTH));
    assign fifoEmpty = (level == '0);
    assign errFlags  = {bus.rxBreakDetect, bus.rxFramingError, bus.rxOverrun};
    assign errRise   = errFlags & ~errFlagsPrev_p0;

    always_comb begin
        rxNext = rxState;
        push   = 1'b0;
        case (rxState)
            RX_IDLE:  if (!bus.rxEmpty && !fifoFull) rxNext = RX_READ;
            RX_READ:  begin
                push   = 1'b1;
                rxNext = RX_WAIT;
            end
            RX_WAIT:  rxNext = RX_IDLE;
            default:  rxNext = RX_IDLE;
        endcase
    end

    always_comb begin
        txNext  = txState;
        pop     = 1'b0;
        loadOut = 1'b0;
        case (txState)
            TX_IDLE:  if (!fifoEmpty && bus.txEmpty) begin
                txNext  = TX_WRITE;
                loadOut = 1'b1;
            end
            TX_WRITE: begin
                pop    = 1'b1;
                txNext = TX_WAIT;
            end
            TX_WAIT:  txNext = TX_IDLE;
            default:  txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or posedge Rst) begin
        if (Rst) begin
            rxState         <= RX_IDLE;
            txState         <= TX_IDLE;
            wrPtr           <= '0;
            rdPtr           <= '0;
            level           <= '0;
            dataoutReg      <= 8'h00;
            busyReg         <= 1'b0;
            errFlagsPrev_p0 <= 3'b000;
            errCnt          <= '0;
        end else begin
            rxState <= rxNext;
            txState <= txNext;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            // Push and pop together leave the occupancy untouched.
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (loadOut) dataoutReg <= mem[rdPtr];
            busyReg         <= !fifoEmpty || (rxState != RX_IDLE) || (txState != TX_IDLE);
            errFlagsPrev_p0 <= errFlags;
            errCnt          <= satAdd(errCnt, countRises(errRise));
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge sysClk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    assign bus.rxRead     = (rxState == RX_READ);
    assign bus.txWrite    = (txState == TX_WRITE);
    assign bus.dataout    = dataoutReg;
    assign bus.fifoLevel  = level;
    assign bus.errorCount = errCnt;
    assign bus.busy       = busyReg;
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: transaction-level scoreboard plus directed scenarios.
module tb_uart_echo_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic Rst = 1'b0;
    always #5 clk = ~clk;

    uart_echo_ctrl_if #(.FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(32)) ifc ();
    uart_echo_ctrl_if #(.FIFO_DEPTH(2), .ERR_CNT_WIDTH(3)) ifc2 ();

    uart_echo_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(32)) dut (
        .sysClk(clk), .Rst(Rst), .bus(ifc)
    );

    uart_echo_ctrl #(.FIFO_DEPTH(2), .ERR_CNT_WIDTH(3)) dutSat (
        .sysClk(clk), .Rst(Rst), .bus(ifc2)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] uartQ[$];
    logic [7:0] expQ[$];
    logic [7:0] txLog[$];
    logic       rdSeen = 1'b0;
    int         rdCount = 0;
    int         txCount = 0;
    int         maxLevel = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] echoOf(logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
        logic [7:0] folded;
        folded = b | 8'h20;
        if (folded >= 8'h61 && folded <= 8'h7A) return b ^ 8'h20;
`endif
        return b;
    endfunction

    // UART receive side: one byte per rxRead, status updated shortly after the edge.
    always @(posedge clk) begin
        if (rdSeen && uartQ.size() > 0) void'(uartQ.pop_front());
        #2;
        ifc.rxEmpty = (uartQ.size() == 0);
        ifc.datain  = (uartQ.size() > 0) ? uartQ[0] : 8'h00;
    end

    // Scoreboard: occupancy = reads - writes, echoes in read order, errors = saturated rising-edge sum.
    int         expLevel = 0;
    longint     expErr = 0;
    logic [2:0] prevFlags = 3'b000;
    logic [7:0] lastTx = 8'h00;
    logic       prevRd = 1'b0;
    logic       prevWr = 1'b0;

    always @(negedge clk) begin
        if (Rst) begin
            check("rstRxRead", 32'(ifc.rxRead), 32'd0);
            check("rstTxWrite", 32'(ifc.txWrite), 32'd0);
            check("rstDataout", 32'(ifc.dataout), 32'd0);
            check("rstFifoLevel", 32'(ifc.fifoLevel), 32'd0);
            check("rstErrorCount", ifc.errorCount, 32'd0);
            check("rstBusy", 32'(ifc.busy), 32'd0);
            expQ.delete();
            expLevel  = 0;
            expErr    = 0;
            prevFlags = 3'b000;
            lastTx    = 8'h00;
            rdSeen    = 1'b0;
            prevRd    = 1'b0;
            prevWr    = 1'b0;
        end else begin
            logic [2:0] cur;
            check("fifoLevel", 32'(ifc.fifoLevel), 32'(expLevel));
            check("errorCount", ifc.errorCount, 32'(expErr));
            check("rxReadWhileEmpty", 32'(ifc.rxRead & ifc.rxEmpty), 32'd0);
            check("rxReadWhenFull", 32'(ifc.rxRead && expLevel == DEPTH), 32'd0);
            check("rxReadPulse", 32'(ifc.rxRead & prevRd), 32'd0);
            check("txWritePulse", 32'(ifc.txWrite & prevWr), 32'd0);
            if (ifc.txWrite) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL echoData: txWrite with dataout 0x%0h, expected no write", ifc.dataout);
                end else begin
                    check("echoData", 32'(ifc.dataout), 32'(expQ[0]));
                    void'(expQ.pop_front());
                    expLevel--;
                end
                lastTx = ifc.dataout;
                txLog.push_back(ifc.dataout);
                txCount++;
            end else begin
                check("dataoutHold", 32'(ifc.dataout), 32'(lastTx));
            end
            if (ifc.rxRead) begin
                expQ.push_back(echoOf(ifc.datain));
                expLevel++;
                rdCount++;
            end
            cur    = {ifc.rxBreakDetect, ifc.rxFramingError, ifc.rxOverrun};
            expErr = expErr + longint'($countones(cur & ~prevFlags));
            if (expErr > 64'hFFFF_FFFF) expErr = 64'hFFFF_FFFF;
            prevFlags = cur;
            rdSeen    = ifc.rxRead;
            prevRd    = ifc.rxRead;
            prevWr    = ifc.txWrite;
            if (int'(ifc.fifoLevel) > maxLevel) maxLevel = int'(ifc.fifoLevel);
        end
    end

    task automatic waitTx(int n, int limit, string name);
        int c = 0;
        while (txLog.size() < n && c < limit) begin
            tick(1);
            c++;
        end
        check(name, 32'(txLog.size()), 32'(n));
    endtask

    task automatic waitLevel(int n, int limit, string name);
        int c = 0;
        while (int'(ifc.fifoLevel) != n && c < limit) begin
            tick(1);
            c++;
        end
        check(name, 32'(ifc.fifoLevel), 32'(n));
    endtask

    initial begin
        int         rxLat, txLat, r0, t0;
        logic [7:0] got, exp55;
        int         satExp[4] = '{3, 6, 7, 7};
        logic [7:0] swapExp[3];

`ifdef UART_ECHO_CASE_SWAP_EN
        exp55   = 8'h75;
        swapExp = '{8'h41, 8'h7A, 8'h31};
`else
        exp55   = 8'h55;
        swapExp = '{8'h61, 8'h5A, 8'h31};
`endif
        ifc.txEmpty         = 1'b1;
        ifc.rxOverrun       = 1'b0;
        ifc.rxFramingError  = 1'b0;
        ifc.rxBreakDetect   = 1'b0;
        ifc2.rxEmpty        = 1'b1;
        ifc2.datain         = 8'h00;
        ifc2.txEmpty        = 1'b0;
        ifc2.rxOverrun      = 1'b0;
        ifc2.rxFramingError = 1'b0;
        ifc2.rxBreakDetect  = 1'b0;
        #1 Rst = 1'b1;
        tick(3);
        check("resetLevel", 32'(ifc.fifoLevel), 32'd0);
        check("resetDataout", 32'(ifc.dataout), 32'd0);
        check("resetBusy", 32'(ifc.busy), 32'd0);
        Rst = 1'b0;
        tick(3);
        check("idleBusy", 32'(ifc.busy), 32'd0);
        check("idleNoRead", 32'(rdCount), 32'd0);

        // Single echo with latency measurement.
        uartQ.push_back(8'h55);
        rxLat = 0;
        txLat = 0;
        got   = 8'h00;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ifc.rxRead && rxLat == 0) rxLat = n;
            if (ifc.txWrite) begin
                txLat = n;
                got   = ifc.dataout;
                break;
            end
        end
        check("rxReadLatency", 32'(rxLat), 32'd2);
        check("txWriteLatency", 32'(txLat), 32'd4);
        check("echo55", 32'(got), 32'(exp55));
        tick(5);
        check("singleReads", 32'(rdCount), 32'd1);
        check("singleWrites", 32'(txCount), 32'd1);
        check("busyAfterEcho", 32'(ifc.busy), 32'd0);

        // Backpressure: transmitter blocked until the FIFO fills.
        ifc.txEmpty = 1'b0;
        txLog.delete();
        r0 = rdCount;
        for (int i = 0; i < 10; i++) uartQ.push_back(8'(i));
        tick(40);
        check("fullReads", 32'(rdCount - r0), 32'd8);
        check("fullLevel", 32'(ifc.fifoLevel), 32'd8);
        check("fullBusy", 32'(ifc.busy), 32'd1);
        tick(10);
        check("fullNoMoreReads", 32'(rdCount - r0), 32'd8);
        ifc.txEmpty = 1'b1;
        waitTx(10, 120, "drainCount");
        for (int i = 0; i < 8; i++) check("drainOrder", 32'(txLog[i]), 32'(i));
        tick(5);
        check("drainLevel", 32'(ifc.fifoLevel), 32'd0);

        // Steady stream at maximum rate.
        maxLevel = 0;
        txLog.delete();
        for (int i = 0; i < 16; i++) uartQ.push_back(8'h80 + 8'(i));
        waitTx(16, 200, "streamCount");
        for (int i = 0; i < 16; i++) check("streamOrder", 32'(txLog[i]), 32'h80 + 32'(i));
        check("streamMaxLevel", 32'(maxLevel), 32'd1);
        tick(5);

        // Error counting.
        check("errStart", ifc.errorCount, 32'd0);
        ifc.rxOverrun      = 1'b1;
        ifc.rxFramingError = 1'b1;
        tick(1);
        check("errTwoEdges", ifc.errorCount, 32'd2);
        tick(10);
        check("errLevelHeld", ifc.errorCount, 32'd2);
        ifc.rxOverrun      = 1'b0;
        ifc.rxFramingError = 1'b0;
        tick(1);
        ifc.rxBreakDetect = 1'b1;
        tick(1);
        ifc.rxBreakDetect = 1'b0;
        tick(1);
        check("errBreak", ifc.errorCount, 32'd3);

        for (int i = 0; i < 4; i++) begin
            ifc2.rxOverrun      = 1'b1;
            ifc2.rxFramingError = 1'b1;
            ifc2.rxBreakDetect  = 1'b1;
            tick(1);
            ifc2.rxOverrun      = 1'b0;
            ifc2.rxFramingError = 1'b0;
            ifc2.rxBreakDetect  = 1'b0;
            tick(1);
            check("errSaturate", 32'(ifc2.errorCount), 32'(satExp[i]));
        end

        // Reset with bytes buffered and a read in flight.
        ifc.txEmpty = 1'b0;
        uartQ.push_back(8'h11);
        uartQ.push_back(8'h22);
        uartQ.push_back(8'h33);
        waitLevel(3, 30, "bufferedLevel");
        check("bufferedBusy", 32'(ifc.busy), 32'd1);
        uartQ.push_back(8'h44);
        tick(2);
        uartQ.delete();
        Rst = 1'b1;
        #1;
        check("asyncRstLevel", 32'(ifc.fifoLevel), 32'd0);
        check("asyncRstRead", 32'(ifc.rxRead), 32'd0);
        check("asyncRstWrite", 32'(ifc.txWrite), 32'd0);
        check("asyncRstDataout", 32'(ifc.dataout), 32'd0);
        check("asyncRstErrors", ifc.errorCount, 32'd0);
        check("asyncRstBusy", 32'(ifc.busy), 32'd0);
        ifc.txEmpty = 1'b1;
        tick(2);
        Rst = 1'b0;
        t0 = txCount;
        r0 = rdCount;
        tick(10);
        check("noWriteAfterRst", 32'(txCount - t0), 32'd0);
        check("noReadAfterRst", 32'(rdCount - r0), 32'd0);
        check("levelAfterRst", 32'(ifc.fifoLevel), 32'd0);

        // Case handling of letters and non-letters.
        txLog.delete();
        uartQ.push_back(8'h61);
        uartQ.push_back(8'h5A);
        uartQ.push_back(8'h31);
        waitTx(3, 60, "caseCount");
        for (int i = 0; i < 3; i++) check("caseEcho", 32'(txLog[i]), 32'(swapExp[i]));
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
